fsmc_bus_master: RTL and testbench

Clocked initiator for the same asynchronous NE/NOE/NWE parallel bus that `clocked_bus_slave` answers. It turns single-word read/write requests from on-chip logic into bus cycles with parameterised setup, strobe and hold phases, all counted in `clk` cycles. It serves as the initiator in FPGA-to-FPGA loopback benches and as the driver for external async-SRAM-style peripherals. Bus strobes come straight from registers, and the data pins go through an `SB_IO` tristate the same way the slave side does it.

---
 rtl/fsmc_bus_master.sv | 160 ++++++++++++++++
 tb/tb_fsmc_bus_master.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fsmc_bus_master.sv
// fsmc_bus_master
// Clocked initiator for an asynchronous NE/NOE/NWE parallel bus. Each accepted
// single-word request becomes one bus cycle made of three phases: address
// setup (ADDSET cycles), strobe (DATAST cycles) and turnaround (HOLD cycles).
// Every bus output comes straight from a register.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   req, we, adr,      request handshake; sampled when req & ready
//   wdata
//   ready              high in IDLE, a request can be taken
//   rdata, rvalid      last read word, one-cycle pulse when it updates
//   aNE, aNOE, aNWE    active-low chip enable / output enable / write enable
//   aAn                bus address
//   aDn_out, aDn_in    data to / from the pad tristate
//   io_output          pad output enable (1 = drive aDn_out)
module fsmc_bus_master #(
    parameter int ADRW   = 8,
    parameter int DATW   = 16,
    parameter int ADDSET = 2,
    parameter int DATAST = 8,
    parameter int HOLD   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            we,
    input  logic [ADRW-1:0] adr,
    input  logic [DATW-1:0] wdata,
    output logic            ready,
    output logic [DATW-1:0] rdata,
    output logic            rvalid,
    output logic            aNE,
    output logic            aNOE,
    output logic            aNWE,
    output logic [ADRW-1:0] aAn,
    output logic [DATW-1:0] aDn_out,
    input  logic [DATW-1:0] aDn_in,
    output logic            io_output
);

    // One shared down-counter covers the longest phase.
    localparam int MAXC = (ADDSET > DATAST) ? ((ADDSET > HOLD) ? ADDSET : HOLD)
                                            : ((DATAST > HOLD) ? DATAST : HOLD);
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] LD_SETUP = CW'(ADDSET - 1);
    localparam logic [CW-1:0] LD_DATA  = CW'(DATAST - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_SETUP = 4'b0010,
        S_DATA  = 4'b0100,
        S_HOLD  = 4'b1000
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            we_q, we_n;
    logic            ne_n, noe_n, nwe_n, io_n, rvalid_n;
    logic [ADRW-1:0] an_n;
    logic [DATW-1:0] dout_n, rdata_n;

    assign ready = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            aNE       <= 1'b1;
            aNOE      <= 1'b1;
            aNWE      <= 1'b1;
            io_output <= 1'b0;
            aAn       <= '0;
            aDn_out   <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            we_q      <= we_n;
            aNE       <= ne_n;
            aNOE      <= noe_n;
            aNWE      <= nwe_n;
            io_output <= io_n;
            aAn       <= an_n;
            aDn_out   <= dout_n;
            rdata     <= rdata_n;
            rvalid    <= rvalid_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        we_n     = we_q;
        ne_n     = aNE;
        noe_n    = aNOE;
        nwe_n    = aNWE;
        io_n     = io_output;
        an_n     = aAn;
        dout_n   = aDn_out;
        rdata_n  = rdata;
        rvalid_n = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (req) begin
                    we_n    = we;
                    an_n    = adr;
                    ne_n    = 1'b0;
                    cnt_n   = LD_SETUP;
                    state_n = S_SETUP;
                    // Reads leave aDn_out at its previous value; the pad is
                    // not driven anyway.
                    if (we) begin
                        dout_n = wdata;
                        io_n   = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    noe_n   = we_q;
                    nwe_n   = ~we_q;
                    cnt_n   = LD_DATA;
                    state_n = S_DATA;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_DATA: begin
                if (cnt == '0) begin
                    // Pad data has been stable for most of the strobe, so it
                    // is captured directly without a synchroniser.
                    if (!we_q) begin
                        rdata_n  = aDn_in;
                        rvalid_n = 1'b1;
                    end
                    ne_n    = 1'b1;
                    noe_n   = 1'b1;
                    nwe_n   = 1'b1;
                    io_n    = 1'b0;
                    cnt_n   = LD_HOLD;
                    state_n = S_HOLD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt == '0) state_n = S_IDLE;
                else           cnt_n   = cnt - CW'(1);
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fsmc_bus_master.sv
// Bench for fsmc_bus_master: default-parameter instance plus a short-phase
// instance (ADDSET=1, DATAST=2, HOLD=1), both driven from one linear sequence.
// A memory-backed bus model answers strobes; a reference memory predicts reads.
module tb_fsmc_bus_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  adr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] aDn_in;
    logic        sel = 1'b0;

    logic        ready1, rvalid1, ne1, noe1, nwe1, io1;
    logic [15:0] rdata1, dout1;
    logic [7:0]  an1;
    logic        ready2, rvalid2, ne2, noe2, nwe2, io2;
    logic [15:0] rdata2, dout2;
    logic [7:0]  an2;
    logic        req1, req2;

    assign req1 = req & ~sel;
    assign req2 = req & sel;

    always #5 clk = ~clk;

    fsmc_bus_master dut1 (
        .clk(clk), .rst(rst), .req(req1), .we(we), .adr(adr), .wdata(wdata),
        .ready(ready1), .rdata(rdata1), .rvalid(rvalid1), .aNE(ne1), .aNOE(noe1),
        .aNWE(nwe1), .aAn(an1), .aDn_out(dout1), .aDn_in(aDn_in), .io_output(io1)
    );

    fsmc_bus_master #(.ADDSET(1), .DATAST(2), .HOLD(1)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .we(we), .adr(adr), .wdata(wdata),
        .ready(ready2), .rdata(rdata2), .rvalid(rvalid2), .aNE(ne2), .aNOE(noe2),
        .aNWE(nwe2), .aAn(an2), .aDn_out(dout2), .aDn_in(aDn_in), .io_output(io2)
    );

    // Observed signals of whichever instance is under test.
    logic        ready_s, rvalid_s, ne_s, noe_s, nwe_s, io_s;
    logic [15:0] rdata_s, dout_s;
    logic [7:0]  an_s;
    assign ready_s  = sel ? ready2  : ready1;
    assign rvalid_s = sel ? rvalid2 : rvalid1;
    assign ne_s     = sel ? ne2     : ne1;
    assign noe_s    = sel ? noe2    : noe1;
    assign nwe_s    = sel ? nwe2    : nwe1;
    assign io_s     = sel ? io2     : io1;
    assign rdata_s  = sel ? rdata2  : rdata1;
    assign dout_s   = sel ? dout2   : dout1;
    assign an_s     = sel ? an2     : an1;

    // Bus model: a plain memory, written while NWE is low, read while NOE is
    // low; random junk on the data lines otherwise.
    logic [15:0] bus_mem [256];
    logic [15:0] junk = 16'h5A5A;
    assign aDn_in = (!noe_s) ? bus_mem[an_s] : junk;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) bus_mem[i] <= '0;
        end else if (!nwe_s && io_s) begin
            bus_mem[an_s] <= dout_s;
        end
    end

    int cyc = 0;
    int ne_falls = 0;
    int io_viol = 0;
    logic ne_prev = 1'b1;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (!ne_s && ne_prev) ne_falls <= ne_falls + 1;
        ne_prev <= ne_s;
        if ((io_s && !noe_s) || (!noe_s && !nwe_s)) io_viol <= io_viol + 1;
        junk <= 16'($urandom);
    end

    // Reference state.
    logic [15:0] ref_mem [256];
    logic [15:0] last_rd = '0;
    int exp_ne = 0;
    int prev_acc = 0;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One transaction; every cycle from the accepting edge (k=0) until ready
    // returns is compared against the phase arithmetic.
    // mode 0: req dropped after accept, 1: req random while busy, 2: req held.
    task automatic txn(input logic w, input logic [7:0] a, input logic [15:0] d,
                       input int mode, input bit chained);
        int A, D, H;
        logic [15:0] exp_rd;
        A = sel ? 1 : 2;
        D = sel ? 2 : 8;
        H = sel ? 1 : 2;
        exp_rd = w ? last_rd : ref_mem[a];
        @(negedge clk);
        req = 1'b1; we = w; adr = a; wdata = d;
        if (w) ref_mem[a] = d;
        @(posedge clk);
        for (int k = 0; k <= A + D + H; k++) begin
            #1;
            if (k == 0) begin
                if (chained) chk("spacing", 32'(cyc - prev_acc), 32'(A + D + H + 1));
                prev_acc = cyc;
            end
            chk("aNE",    ne_s,    !(k < A + D));
            chk("aNOE",   noe_s,   !(!w && k >= A && k < A + D));
            chk("aNWE",   nwe_s,   !(w && k >= A && k < A + D));
            chk("io",     io_s,    w && k < A + D);
            chk("ready",  ready_s, k >= A + D + H);
            chk("rvalid", rvalid_s, !w && k == A + D);
            chk("rdata",  rdata_s, (!w && k >= A + D) ? exp_rd : last_rd);
            chk("aAn",    an_s,    a);
            if (w) chk("aDn_out", dout_s, d);
            if (k < A + D + H) begin
                @(negedge clk);
                if (mode == 1 && k < A + D + H - 1) req = 1'($urandom);
                else req = (mode == 2);
                @(posedge clk);
            end
        end
        if (!w) last_rd = exp_rd;
        if (w) chk("bus_mem", bus_mem[a], d);
        exp_ne++;
    endtask

    task automatic rand_txn(input int mode);
        txn(1'($urandom), 8'($urandom_range(0, 7)), 16'($urandom), mode, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_aNE", ne1, 1);
        chk("rst_aNOE", noe1, 1);
        chk("rst_aNWE", nwe1, 1);
        chk("rst_io", io1, 0);
        chk("rst_ready", ready1, 1);
        chk("rst_rvalid", rvalid1, 0);
        chk("rst_rdata", rdata1, 0);
        chk("rst_aAn", an1, 0);
        chk("rst_aDn_out", dout1, 0);
        chk("rst_ready2", ready2, 1);
        @(negedge clk) rst = 1'b0;

        // Directed write, then a read of a word placed by a prior write.
        txn(1'b1, 8'h03, 16'h1234, 0, 1'b0);
        txn(1'b1, 8'h02, 16'hBEEF, 0, 1'b0);
        txn(1'b0, 8'h02, 16'h0000, 0, 1'b0);
        txn(1'b0, 8'h03, 16'h0000, 0, 1'b0);

        // Three writes with req held high throughout.
        txn(1'b1, 8'h00, 16'($urandom), 2, 1'b0);
        txn(1'b1, 8'h01, 16'($urandom), 2, 1'b1);
        txn(1'b1, 8'h04, 16'($urandom), 2, 1'b1);
        @(negedge clk) req = 1'b0;

        // Random traffic with req toggling while busy.
        repeat (10) rand_txn(1);
        @(negedge clk) req = 1'b0;

        // Reset during the strobe phase of a read.
        @(negedge clk);
        req = 1'b1; we = 1'b0; adr = 8'h02;
        @(posedge clk);
        @(negedge clk) req = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_aNE", ne1, 1);
        chk("abort_aNOE", noe1, 1);
        chk("abort_aNWE", nwe1, 1);
        chk("abort_io", io1, 0);
        chk("abort_ready", ready1, 1);
        chk("abort_rdata", rdata1, 0);
        chk("abort_rvalid", rvalid1, 0);
        @(negedge clk) rst = 1'b0;
        exp_ne++;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        last_rd = '0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            chk("post_abort_rvalid", rvalid1, 0);
            chk("post_abort_rdata", rdata1, 0);
        end

        // Short-phase instance.
        @(negedge clk) sel = 1'b1;
        txn(1'b1, 8'h05, 16'hCAFE, 0, 1'b0);
        txn(1'b0, 8'h05, 16'h0000, 0, 1'b0);
        repeat (6) rand_txn(0);
        txn(1'b1, 8'h06, 16'($urandom), 2, 1'b0);
        txn(1'b0, 8'h06, 16'h0000, 2, 1'b1);
        @(negedge clk) req = 1'b0;
        repeat (6) rand_txn(1);
        @(negedge clk) req = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("ne_fall_count", 32'(ne_falls), 32'(exp_ne));
        chk("io_noe_overlap", 32'(io_viol), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
